// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl
//   Sequencer for a ROWS x COLS weight-stationary systolic array.
//   Each job runs through these phases:
//     1. Preload one weight row per cycle.
//     2. Stream N ifmap/psum vectors.
//     3. Drain the array pipeline while flagging valid outputs.
//     4. Pulse done.
//   Every output is a flop. Each one is loaded from the next-state decode, so
//   outputs line up with the state that the FSM occupies in that cycle.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   start_i      in   job request, only honoured in IDLE
//   num_vec_i    in   vector count N, latched when start_i is accepted
//   abort_i      in   cancel the running job (no done pulse)
//   busy_o       out  high in every state except IDLE
//   done_o       out  one-cycle pulse at job completion
//   weight_en_o  out  PE weight register load enable
//   weight_row_o out  weight row being loaded / weight buffer read address
//   ifmap_en_o   out  PE ifmap enable and ifmap buffer read strobe
//   psum_en_o    out  PE psum enable (same as ifmap_en_o)
//   vec_idx_o    out  index of the vector streamed this cycle
//   obuf_wr_o    out  array output valid / output buffer write strobe

module pe_array_ctrl #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int VEC_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [VEC_W-1:0]        num_vec_i,
  input  logic                    abort_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    weight_en_o,
  output logic [$clog2(ROWS)-1:0] weight_row_o,
  output logic                    ifmap_en_o,
  output logic                    psum_en_o,
  output logic [VEC_W-1:0]        vec_idx_o,
  output logic                    obuf_wr_o
);

  // Cycles from an ifmap enable to the matching valid array output.
  localparam int LAT = ROWS + COLS - 1;
  localparam int RW  = $clog2(ROWS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [VEC_W-1:0] r_cnt;
  logic [VEC_W-1:0] w_cnt_nxt;
  logic [VEC_W-1:0] r_num;
  logic [VEC_W-1:0] w_num_nxt;
  logic             w_abort;

  logic             r_busy;
  logic             r_done;
  logic             r_wen;
  logic [RW-1:0]    r_row;
  logic             r_ifen;
  logic [VEC_W-1:0] r_idx;
  logic [LAT-1:0]   r_dly;

  // Abort only acts on a running job.
  // It wins over everything else, including a simultaneous start.
  assign w_abort = abort_i && (r_state != S_IDLE);

  // Next-state and counter logic.
  // One shared counter walks each phase:
  //   LOAD_W : weight rows
  //   STREAM : vectors
  //   DRAIN  : pipeline depth
  // The counter restarts from zero at every phase change.
  // A STREAM phase compares against N-1 and is never entered with N=0, so
  // N=2^VEC_W-1 completes without the counter wrapping.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_num_nxt   = r_num;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt_nxt = '0;
          if (start_i && !abort_i) begin
            w_state_nxt = S_LOAD_W;
            w_num_nxt   = num_vec_i;
          end
        end
        S_LOAD_W: begin
          if (r_cnt == VEC_W'(ROWS - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = (r_num == '0) ? S_DONE : S_STREAM;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_STREAM: begin
          if (r_cnt == r_num - 1'b1) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_DRAIN;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_cnt == VEC_W'(LAT - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  // Outputs are decoded from the next state, so they are valid in the same
  // cycle as the state they describe.
  // The delay line turns each ifmap enable into an output-valid strobe LAT
  // cycles later. It is emptied on abort so a cancelled job leaves nothing
  // behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_num   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wen   <= 1'b0;
      r_row   <= '0;
      r_ifen  <= 1'b0;
      r_idx   <= '0;
      r_dly   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_num   <= w_num_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
      r_wen   <= (w_state_nxt == S_LOAD_W);
      r_row   <= (w_state_nxt == S_LOAD_W) ? w_cnt_nxt[RW-1:0] : '0;
      r_ifen  <= (w_state_nxt == S_STREAM);
      r_idx   <= (w_state_nxt == S_STREAM) ? w_cnt_nxt : '0;
      if (w_abort) begin
        r_dly <= '0;
      end else begin
        r_dly <= {r_dly[LAT-2:0], r_ifen};
      end
    end
  end

  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign weight_en_o  = r_wen;
  assign weight_row_o = r_row;
  assign ifmap_en_o   = r_ifen;
  assign psum_en_o    = r_ifen;
  assign vec_idx_o    = r_idx;
  assign obuf_wr_o    = r_dly[LAT-1];

endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb_pe_array_ctrl
//   Directed bench for pe_array_ctrl with ROWS=COLS=4 (LAT=7).
//   Each test drives start/abort/reset on chosen cycles. It compares the
//   packed output word every cycle against a timeline built from the job's
//   start cycle and vector count.
//   Packed word layout:
//     {busy, done, weight_en, weight_row[1:0], ifmap_en, psum_en,
//      vec_idx[15:0], obuf_wr}

module tb_pe_array_ctrl;

  localparam int LAT = 7;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [15:0] num_vec_i;
  logic        abort_i;
  logic        busy_o;
  logic        done_o;
  logic        weight_en_o;
  logic [1:0]  weight_row_o;
  logic        ifmap_en_o;
  logic        psum_en_o;
  logic [15:0] vec_idx_o;
  logic        obuf_wr_o;

  int nVec = 0;
  int nMis = 0;

  pe_array_ctrl #(.ROWS(4), .COLS(4), .VEC_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .num_vec_i    (num_vec_i),
    .abort_i      (abort_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .weight_en_o  (weight_en_o),
    .weight_row_o (weight_row_o),
    .ifmap_en_o   (ifmap_en_o),
    .psum_en_o    (psum_en_o),
    .vec_idx_o    (vec_idx_o),
    .obuf_wr_o    (obuf_wr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] outs;
  assign outs = {busy_o, done_o, weight_en_o, weight_row_o, ifmap_en_o,
                 psum_en_o, vec_idx_o, obuf_wr_o};

  // Expected output word in cycle c for a job whose start_i is seen in cycle
  // s with n vectors. Returns 0 outside that job's lifetime.
  function automatic logic [23:0] jobVec(input int c, input int s, input int n);
    int          rel;
    int          doneRel;
    logic        busy;
    logic        done;
    logic        wen;
    logic        ifen;
    logic        obuf;
    logic [1:0]  row;
    logic [15:0] idx;
    rel     = c - s;
    doneRel = (n == 0) ? 5 : 5 + n + LAT;
    busy    = (rel >= 1) && (rel <= doneRel);
    done    = (rel == doneRel);
    wen     = (rel >= 1) && (rel <= 4);
    row     = wen ? 2'(rel - 1) : 2'd0;
    ifen    = (n > 0) && (rel >= 5) && (rel < 5 + n);
    idx     = ifen ? 16'(rel - 5) : 16'd0;
    obuf    = (n > 0) && (rel >= 5 + LAT) && (rel < 5 + n + LAT);
    return {busy, done, wen, row, ifen, ifen, idx, obuf};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One cycle:
  //   1. At the falling edge, check this cycle's outputs.
  //   2. Drive the inputs that the next rising edge will sample.
  task automatic applyStimulus(input string tag, input int c, input logic st,
                               input logic ab, input logic rs,
                               input logic [15:0] n, input logic [23:0] exp);
    @(negedge clk);
    checkOutput($sformatf("%s c%0d", tag, c), {8'h0, outs}, {8'h0, exp});
    start_i   = st;
    abort_i   = ab;
    rst       = rs;
    num_vec_i = n;
  endtask

  int   ifCnt;
  int   obCnt;
  int   idxErr;
  int   doneCyc;
  int   expIdx;
  logic doneSeen;

  initial begin
    rst       = 1'b1;
    start_i   = 1'b0;
    abort_i   = 1'b0;
    num_vec_i = 16'd0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset", {8'h0, outs}, 32'h0);
    rst = 1'b0;

    // T1/T3/T6:
    //   N=3 job with start_i held high through DONE. The vector count
    //   changes after acceptance. A second job (N=1) is accepted in cycle 16.
    for (int c = 0; c <= 31; c++)
      applyStimulus("T1", c, (c <= 16), 1'b0, 1'b0,
                    (c == 0) ? 16'd3 : 16'd1,
                    jobVec(c, 0, 3) | jobVec(c, 16, 1));

    // T2: N=0 goes straight from weight load to done.
    for (int c = 0; c <= 8; c++)
      applyStimulus("T2", c, (c == 0), 1'b0, 1'b0, 16'd0, jobVec(c, 0, 0));

    // T4: N=10 aborted mid-stream; nothing may follow, not even obuf writes.
    for (int c = 0; c <= 22; c++)
      applyStimulus("T4", c, (c == 0), (c == 8), 1'b0, 16'd10,
                    (c <= 8) ? jobVec(c, 0, 10) : 24'h0);

    // T5: N=5 reset mid-job, then a clean N=2 job started in cycle 8.
    for (int c = 0; c <= 25; c++)
      applyStimulus("T5", c, (c == 0) || (c == 8), 1'b0, (c == 6),
                    (c == 0) ? 16'd5 : 16'd2,
                    (c <= 6) ? jobVec(c, 0, 5) :
                    (c >= 8) ? jobVec(c, 8, 2) : 24'h0);

    // TMAX: largest vector count must stream completely without wrapping.
    applyStimulus("TMAX", 0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 24'h0);
    ifCnt    = 0;
    obCnt    = 0;
    idxErr   = 0;
    expIdx   = 0;
    doneCyc  = -1;
    doneSeen = 1'b0;
    for (int c = 1; c < 70000 && !doneSeen; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (ifmap_en_o) begin
        if (vec_idx_o != 16'(expIdx)) idxErr++;
        expIdx++;
        ifCnt++;
      end
      if (obuf_wr_o) obCnt++;
      if (done_o) begin
        doneSeen = 1'b1;
        doneCyc  = c;
      end
    end
    checkOutput("TMAX done cycle", 32'(doneCyc), 32'd65547);
    checkOutput("TMAX ifmap pulses", 32'(ifCnt), 32'd65535);
    checkOutput("TMAX obuf pulses", 32'(obCnt), 32'd65535);
    checkOutput("TMAX idx errors", 32'(idxErr), 32'd0);
    applyStimulus("TMAX idle", 0, 1'b0, 1'b0, 1'b0, 16'd0, 24'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
